alu_issue_1210606: RTL and testbench
====================================

# alu_issue_1210606

Sequenced front-end for the 4-bit signed ALU (`N`-bit operands, 3-bit opcode, `N+2`-bit signed result).
- Accepts operand/opcode commands over a valid/ready handshake and holds them stable on the ALU inputs for a programmable settle time.
- Captures the ALU result into a small FIFO and presents it downstream with its opcode and zero/negative flags.
- Sits directly upstream of the ALU: drives its `x`, `y` and `c` inputs and consumes its `o` output.

## Interface
- `N`, 4: operand width; result width is `N+2`.
- `SETTLE`, 1: cycles the operands are held on the ALU before capture; must be ≥1.
- `DEPTH`, 4: result FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  command accepted when `in_valid && in_ready` at a clock edge.
- `in_x`, `in_y`  in  `N`  signed operands.
- `in_op`  in  3  ALU opcode.
- `alu_x`, `alu_y`  out  `N`  registered operands to the ALU.
- `alu_c`  out  3  registered opcode to the ALU.
- `alu_o`  in  `N+2`  ALU result, combinational from `alu_x`/`alu_y`/`alu_c`.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  pop the head entry when `out_valid && out_ready`.
- `out_result`  out  `N+2`  head result.
- `out_op`  out  3  head opcode.
- `out_zero`, `out_neg`  out  1  head result is 0 / head result MSB.
- `fill`  out  `$clog2(DEPTH)+1`  FIFO occupancy.

## Operation
- FSM states:
  - IDLE:
    - `in_ready=1`.
    - On accept: load `alu_x/alu_y/alu_c` from `in_*`, load settle counter with `SETTLE-1`, go to DRIVE.
  - DRIVE:
    - `in_ready=0`.
    - While the counter is >0, decrement it.
    - When the counter is 0 and a push is possible, write `{alu_o, alu_c}` into the FIFO and go to IDLE.
    - When the counter is 0 and no push is possible, hold in DRIVE with operands unchanged (backpressure).
- Push is possible when `fill < DEPTH`, or when `fill == DEPTH` and a pop occurs on the same edge.
- Simultaneous push and pop leaves `fill` unchanged.
- Pointers wrap modulo `DEPTH`.
- `alu_x/alu_y/alu_c` keep their last values in IDLE.
- The result is stored unmodified (no re-extension).
- `out_zero`/`out_neg` are combinational from the FIFO head.
- Popping an empty FIFO is ignored; `out_*` data is don't-care when `out_valid=0`.

## Timing
- Reset values:
  - state IDLE; `in_ready=1`.
  - `alu_x=alu_y=0`, `alu_c=0`.
  - FIFO empty: `fill=0`, `out_valid=0`.
  - `out_result=0`, `out_op=0`, `out_zero=1`, `out_neg=0`.
- Latency, FIFO empty:
  - Command accepted at edge k → ALU inputs valid after edge k.
  - Result written at edge k+`SETTLE`.
  - `out_valid=1` in the cycle after edge k+`SETTLE`.
- Throughput: one command per `SETTLE+1` cycles, because IDLE always takes one cycle.
- Reset asserted mid-operation: the in-flight command and all FIFO contents are discarded immediately, without waiting for a clock.
- `in_*` are sampled only at the accept edge; later changes have no effect.

## Structure
- Package `alu_pkg_1210606` holds:
  - opcode width constant `OP_W=3`;
  - the FSM state enum (IDLE, DRIVE);
  - the result-width helper `RES_W(N)=N+2`.
- Sub-module `res_fifo_1210606` is a parameterised synchronous FIFO (width `N+5`, depth `DEPTH`) with push/pop/`fill` and same-edge push+pop when full.
- The top level contains only the FSM, the settle counter and the ALU-side registers.
- The bench connects the real ALU or a stub to `alu_o`.

## Test plan
- Single command, `SETTLE=1`, stub `alu_o=6'sd5` for x=3, y=2, op=0, `out_ready=1` → `out_valid` one cycle after edge k+1; result 5, op 0, zero 0, neg 0; `fill` returns to 0.
- `SETTLE=3`, stub `alu_o=-6'sd4` → `alu_x/alu_y/alu_c` stable for 3 cycles; result -4 with `out_neg=1`; `in_ready=0` throughout DRIVE.
- `out_ready=0`, issue 5 commands with `DEPTH=4` → `fill` reaches 4; fifth command held in DRIVE with `in_ready=0`. Assert `out_ready` for one cycle → fifth result pushed on that same edge; `fill` stays 4; results pop in issue order.
- Stub `alu_o=0` → `out_zero=1`; `out_neg=0`.
- Assert `rst_n` low mid-DRIVE with `fill=2` → `out_valid=0`, `fill=0`, `in_ready=1`, `alu_*=0` immediately. A new command after release completes normally.
- Random `in_valid`/`out_ready`, 1000 commands, against a reference queue → no loss, duplication or reordering; `fill` never exceeds `DEPTH`.

Source files
------------

// File: rtl/alu_pkg_1210606.sv
// Shared types and constants for the sequenced ALU front-end.
package alu_pkg_1210606;

  localparam int OP_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  function automatic int RES_W(input int n);
    return n + 2;
  endfunction

endpackage

// File: rtl/res_fifo_1210606.sv
// Synchronous result FIFO; a push is taken on a full FIFO when a pop happens on the same edge.
module res_fifo_1210606 #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (fill == '0);
  assign full    = (fill == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   fill <= fill + (AW+1)'(1);
        2'b01:   fill <= fill - (AW+1)'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Storage is data-only; validity is tracked by the pointers and fill.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Empty FIFO presents zero so the head reads as a clean zero after reset.
  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/alu_issue_1210606.sv
// Issues one command at a time to a combinational ALU, holds it for SETTLE cycles, queues the result.
module alu_issue_1210606
  import alu_pkg_1210606::*;
#(
  parameter int N      = 4,
  parameter int SETTLE = 1,
  parameter int DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [N-1:0]           in_x,
  input  logic signed [N-1:0]           in_y,
  input  logic        [OP_W-1:0]        in_op,
  output logic signed [N-1:0]           alu_x,
  output logic signed [N-1:0]           alu_y,
  output logic        [OP_W-1:0]        alu_c,
  input  logic signed [RES_W(N)-1:0]    alu_o,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [RES_W(N)-1:0]    out_result,
  output logic        [OP_W-1:0]        out_op,
  output logic                          out_zero,
  output logic                          out_neg,
  output logic [$clog2(DEPTH):0]        fill
);

  localparam int RW    = RES_W(N);
  localparam int FW    = RW + OP_W;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [FW-1:0]    head;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  // A full FIFO still takes the result when the head leaves on the same edge.
  assign push   = (state == DRIVE) && (cnt == '0) && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = DRIVE;
      end
      DRIVE: begin
        if (push) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand hold registers and settle counter; operands only change on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_x <= '0;
      alu_y <= '0;
      alu_c <= '0;
      cnt   <= '0;
    end else if (accept) begin
      alu_x <= in_x;
      alu_y <= in_y;
      alu_c <= in_op;
      cnt   <= CNT_INIT;
    end else if (state == DRIVE && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  res_fifo_1210606 #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({alu_o, alu_c}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .fill  (fill)
  );

  assign out_valid  = !empty;
  assign out_result = head[FW-1:OP_W];
  assign out_op     = head[OP_W-1:0];
  assign out_zero   = (out_result == '0);
  assign out_neg    = out_result[RW-1];

endmodule

// File: tb/tb_alu_issue_1210606.sv
// Directed and randomized checks of the ALU front-end using a behavioural ALU stub.
module tb_alu_issue_1210606;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [5:0] stub(input logic signed [3:0] x,
                                             input logic signed [3:0] y,
                                             input logic [2:0] op);
    logic signed [5:0] xe;
    logic signed [5:0] ye;
    xe = x;
    ye = y;
    case (op)
      3'd0:    return xe + ye;
      3'd1:    return xe - ye;
      3'd2:    return xe & ye;
      3'd3:    return xe | ye;
      3'd4:    return xe ^ ye;
      3'd5:    return -xe;
      3'd6:    return xe;
      default: return ye;
    endcase
  endfunction

  // Instance A: SETTLE=1
  logic              a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_zero, a_neg;
  logic signed [3:0] a_in_x, a_in_y, a_alu_x, a_alu_y;
  logic        [2:0] a_in_op, a_alu_c, a_out_op, a_fill;
  logic signed [5:0] a_alu_o, a_out_result;
  assign a_alu_o = stub(a_alu_x, a_alu_y, a_alu_c);

  alu_issue_1210606 #(.N(4), .SETTLE(1), .DEPTH(4)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_x(a_in_x), .in_y(a_in_y), .in_op(a_in_op),
    .alu_x(a_alu_x), .alu_y(a_alu_y), .alu_c(a_alu_c), .alu_o(a_alu_o),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_result(a_out_result),
    .out_op(a_out_op), .out_zero(a_zero), .out_neg(a_neg), .fill(a_fill)
  );

  // Instance B: SETTLE=3
  logic              b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_zero, b_neg;
  logic signed [3:0] b_in_x, b_in_y, b_alu_x, b_alu_y;
  logic        [2:0] b_in_op, b_alu_c, b_out_op, b_fill;
  logic signed [5:0] b_alu_o, b_out_result;
  assign b_alu_o = stub(b_alu_x, b_alu_y, b_alu_c);

  alu_issue_1210606 #(.N(4), .SETTLE(3), .DEPTH(4)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_x(b_in_x), .in_y(b_in_y), .in_op(b_in_op),
    .alu_x(b_alu_x), .alu_y(b_alu_y), .alu_c(b_alu_c), .alu_o(b_alu_o),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result),
    .out_op(b_out_op), .out_zero(b_zero), .out_neg(b_neg), .fill(b_fill)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_a(input logic signed [3:0] x, input logic signed [3:0] y,
                         input logic [2:0] op);
    int n;
    n = 0;
    a_in_valid = 1'b1; a_in_x = x; a_in_y = y; a_in_op = op;
    while (!a_in_ready && n < 100) begin step(); n++; end
    if (n >= 100) check("a_issue_timeout", n, 0);
    step();
    a_in_valid = 1'b0;
  endtask

  task automatic issue_b(input logic signed [3:0] x, input logic signed [3:0] y,
                         input logic [2:0] op);
    int n;
    n = 0;
    b_in_valid = 1'b1; b_in_x = x; b_in_y = y; b_in_op = op;
    while (!b_in_ready && n < 100) begin step(); n++; end
    if (n >= 100) check("b_issue_timeout", n, 0);
    step();
    b_in_valid = 1'b0;
  endtask

  task automatic pop_a(input string tag, input logic signed [5:0] res, input logic [2:0] op);
    check({tag, "_valid"}, a_out_valid, 1);
    check({tag, "_result"}, a_out_result, res);
    check({tag, "_op"}, a_out_op, op);
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
  endtask

  logic signed [5:0] ref_res[$];
  logic        [2:0] ref_op[$];

  initial begin
    int acc_n;
    int cyc;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_x = '0; a_in_y = '0; a_in_op = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_x = '0; b_in_y = '0; b_in_op = '0; b_out_ready = 1'b0;
    step(); step();

    check("rst_in_ready", a_in_ready, 1);
    check("rst_alu_x", a_alu_x, 0);
    check("rst_alu_y", a_alu_y, 0);
    check("rst_alu_c", a_alu_c, 0);
    check("rst_fill", a_fill, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_result", a_out_result, 0);
    check("rst_out_op", a_out_op, 0);
    check("rst_out_zero", a_zero, 1);
    check("rst_out_neg", a_neg, 0);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    step();

    // Single command, SETTLE=1: 3+2 -> 5
    a_in_valid = 1'b1; a_in_x = 4'sd3; a_in_y = 4'sd2; a_in_op = 3'd0;
    step();
    a_in_valid = 1'b0;
    check("t1_in_ready_drive", a_in_ready, 0);
    check("t1_alu_x", a_alu_x, 3);
    check("t1_alu_y", a_alu_y, 2);
    check("t1_out_valid_early", a_out_valid, 0);
    step();
    check("t1_out_valid", a_out_valid, 1);
    check("t1_result", a_out_result, 5);
    check("t1_op", a_out_op, 0);
    check("t1_zero", a_zero, 0);
    check("t1_neg", a_neg, 0);
    check("t1_fill", a_fill, 1);
    step();
    check("t1_fill_after_pop", a_fill, 0);
    check("t1_out_valid_after_pop", a_out_valid, 0);

    // SETTLE=3: -1-3 -> -4, operands held for three cycles
    b_in_valid = 1'b1; b_in_x = -4'sd1; b_in_y = 4'sd3; b_in_op = 3'd1;
    step();
    b_in_valid = 1'b0; b_in_x = 4'sd7; b_in_y = 4'sd7; b_in_op = 3'd7;
    for (int i = 0; i < 3; i++) begin
      check("t2_in_ready", b_in_ready, 0);
      check("t2_alu_x", b_alu_x, -1);
      check("t2_alu_y", b_alu_y, 3);
      check("t2_alu_c", b_alu_c, 1);
      check("t2_out_valid_early", b_out_valid, 0);
      step();
    end
    check("t2_out_valid", b_out_valid, 1);
    check("t2_result", b_out_result, -4);
    check("t2_neg", b_neg, 1);
    check("t2_zero", b_zero, 0);
    check("t2_in_ready_idle", b_in_ready, 1);
    check("t2_fill", b_fill, 1);

    // Backpressure: four results fill the FIFO, the fifth waits in DRIVE
    a_out_ready = 1'b0;
    issue_a(4'sd1, 4'sd1, 3'd0);
    issue_a(4'sd5, 4'sd2, 3'd1);
    issue_a(4'sd6, 4'sd3, 3'd2);
    issue_a(4'sd4, 4'sd1, 3'd3);
    issue_a(4'sd7, -4'sd8, 3'd4);
    step(); step(); step();
    check("t3_fill_full", a_fill, 4);
    check("t3_in_ready_held", a_in_ready, 0);
    check("t3_alu_x_held", a_alu_x, 7);
    check("t3_alu_y_held", a_alu_y, -8);
    pop_a("t3_pop1", 6'sd2, 3'd0);
    check("t3_fill_push_pop", a_fill, 4);
    check("t3_in_ready_released", a_in_ready, 1);
    pop_a("t3_pop2", 6'sd3, 3'd1);
    pop_a("t3_pop3", 6'sd2, 3'd2);
    pop_a("t3_pop4", 6'sd5, 3'd3);
    pop_a("t3_pop5", -6'sd1, 3'd4);
    check("t3_fill_drained", a_fill, 0);

    // Zero result
    issue_a(4'sd3, -4'sd3, 3'd0);
    step();
    check("t4_valid", a_out_valid, 1);
    check("t4_result", a_out_result, 0);
    check("t4_zero", a_zero, 1);
    check("t4_neg", a_neg, 0);
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;

    // Asynchronous reset mid-DRIVE with two results queued
    issue_b(4'sd2, 4'sd2, 3'd0);
    issue_b(4'sd1, 4'sd0, 3'd0);
    check("t5_fill_before", b_fill, 2);
    check("t5_in_ready_before", b_in_ready, 0);
    #2;
    b_rst_n = 1'b0;
    #1;
    check("t5_out_valid", b_out_valid, 0);
    check("t5_fill", b_fill, 0);
    check("t5_in_ready", b_in_ready, 1);
    check("t5_alu_x", b_alu_x, 0);
    check("t5_alu_y", b_alu_y, 0);
    check("t5_alu_c", b_alu_c, 0);
    step();
    b_rst_n = 1'b1;
    issue_b(4'sd2, -4'sd1, 3'd1);
    step(); step(); step();
    check("t5_new_valid", b_out_valid, 1);
    check("t5_new_result", b_out_result, 3);
    check("t5_new_fill", b_fill, 1);

    // Random handshakes against a reference queue
    acc_n = 0;
    cyc = 0;
    while ((acc_n < 1000 || ref_res.size() != 0) && cyc < 20000) begin
      a_in_valid  = (acc_n < 1000) && ($urandom_range(0, 3) != 0);
      a_in_x      = 4'($urandom);
      a_in_y      = 4'($urandom);
      a_in_op     = 3'($urandom);
      a_out_ready = ($urandom_range(0, 1) == 1);
      if (a_in_valid && a_in_ready) begin
        ref_res.push_back(stub(a_in_x, a_in_y, a_in_op));
        ref_op.push_back(a_in_op);
        acc_n++;
      end
      if (a_out_valid && a_out_ready) begin
        if (ref_res.size() == 0) check("rnd_pop_unexpected", ref_res.size(), 1);
        else begin
          check("rnd_result", a_out_result, ref_res.pop_front());
          check("rnd_op", a_out_op, ref_op.pop_front());
        end
      end
      step();
      cyc++;
      check("rnd_fill_bound", a_fill > 3'd4, 0);
    end
    a_in_valid = 1'b0;
    check("rnd_accepted", acc_n, 1000);
    check("rnd_drained", ref_res.size(), 0);
    check("rnd_fifo_empty", a_fill, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
